// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch stage of the 16-bit processor.
// Parameter defaults live here so the top and the bench agree on them.
package instr_fetch_unit_pkg;

  localparam int INSTR_W          = 16;
  localparam int OPCODE_W         = 4;
  localparam int ADDR_W_DEFAULT   = 8;
  localparam int DEPTH_DEFAULT    = 4;
  localparam int RESET_PC_DEFAULT = 0;

  // Opcode sits in the top bits of every instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of WIDTH bits, synchronous clear, count output.
// Callers guarantee no push when full and no pop when empty.
module instr_fetch_unit_fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-word reads to instruction memory,
// buffers returns in a prefetch FIFO and hands {instr, pc} to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                DEPTH    = DEPTH_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]      imem_rdata,
  input  logic                    branch_taken,
  input  logic [ADDR_W-1:0]       branch_target,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_W-1:0]      instr_data,
  output logic [ADDR_W-1:0]       instr_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]         fetch_pc;
  logic [ADDR_W-1:0]         inflight_pc;
  logic                      inflight;
  logic                      discard;
  logic                      push;
  logic                      pop;
  logic [CNT_W-1:0]          count;
  logic [INSTR_W+ADDR_W-1:0] head;

  // Counting the in-flight word against free space means a returning word
  // always finds a slot, so the FIFO can never overflow.
  assign imem_req  = reset && !branch_taken &&
                     ((count + CNT_W'(inflight)) < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc;

  // Handshake: an instruction transfers in any cycle where instr_valid and
  // instr_ready are both high; while valid is high and ready low the head
  // (instr_data/instr_pc) holds. A redirect overrides push, pop and issue.
  assign push = inflight && !discard && !branch_taken;
  assign pop  = instr_valid && instr_ready && !branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      discard     <= 1'b0;
    end else begin
      inflight <= imem_req;
      discard  <= branch_taken;
      if (imem_req) inflight_pc <= fetch_pc;
      if (branch_taken)  fetch_pc <= branch_target;
      else if (imem_req) fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  instr_fetch_unit_fetch_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (branch_taken),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata, inflight_pc}),
    .rdata (head),
    .count (count)
  );

  // Outputs read as zero whenever nothing valid is at the head.
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? head[ADDR_W +: INSTR_W] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_W-1:0]        : '0;
  assign fifo_count  = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed latency/redirect/reset checks plus a
// randomized run scored against the expected in-order pc stream.
module tb_instr_fetch_unit;

  localparam int                ADDR_W   = 8;
  localparam int                DEPTH    = 4;
  localparam int                CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata = 16'h0;
  logic              branch_taken = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [15:0]       instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  fifo_count;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .fifo_count    (fifo_count)
  );

  // Instruction memory: one-cycle read latency, junk when not requested.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem[imem_addr] : 16'($urandom);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic branch_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // After reset or a redirect, decode must see consecutive pcs from the start.
  task automatic load_stream(input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back(p);
      p = p + 8'd1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      load_stream(RESET_PC);
      branch_d <= 1'b0;
    end else begin
      if (branch_d) check("valid_after_branch", 32'(instr_valid), 32'd0);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          check("head_pc", 32'(instr_pc), 32'(exp_q[0]));
          check("head_data", 32'(instr_data), 32'(mem[exp_q[0]]));
          if (instr_ready && !branch_taken) void'(exp_q.pop_front());
        end
      end
      if (branch_taken) load_stream(branch_target);
      branch_d <= branch_taken;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),    32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_count"}, 32'(fifo_count),  32'd0);
    check({tag, "_data"},  32'(instr_data),  32'd0);
    check({tag, "_pc"},    32'(instr_pc),    32'd0);
  endtask

  logic [ADDR_W-1:0] wrap_pcs [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    wrap_pcs[0] = 8'hFE; wrap_pcs[1] = 8'hFF; wrap_pcs[2] = 8'h00; wrap_pcs[3] = 8'h01;

    #1 reset = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");

    // Release: first req in cycle 0, first valid in cycle 2, then 1/cycle.
    reset = 1'b1; instr_ready = 1'b1;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'(RESET_PC));
    tick();
    check("valid_cycle1", 32'(instr_valid), 32'd0);
    tick();
    check("valid_cycle2", 32'(instr_valid), 32'd1);
    check("first_pc", 32'(instr_pc), 32'(RESET_PC));
    check("first_data", 32'(instr_data), 32'h0100);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("stream_valid", 32'(instr_valid), 32'd1);
      check("stream_pc", 32'(instr_pc), 32'(RESET_PC + 8'(k)));
    end

    // Backpressure fills the FIFO and stops issue.
    instr_ready = 1'b0;
    repeat (10) tick();
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_req", 32'(imem_req), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 6; k++) begin
      check("steady_count", 32'(fifo_count), 32'd2);
      check("steady_valid", 32'(instr_valid), 32'd1);
      tick();
    end

    // Redirect with a request in flight.
    branch_taken = 1'b1; branch_target = 8'h20;
    #1;
    check("branch_req", 32'(imem_req), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("r1_valid", 32'(instr_valid), 32'd0);
    check("r1_req", 32'(imem_req), 32'd1);
    check("r1_addr", 32'(imem_addr), 32'h20);
    tick();
    check("r2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("r3_valid", 32'(instr_valid), 32'd1);
    check("r3_pc", 32'(instr_pc), 32'h20);
    check("r3_data", 32'(instr_data), 32'h0120);

    // Back-to-back redirects: the last one wins, and the pc wraps.
    branch_taken = 1'b1; branch_target = 8'h50;
    tick();
    branch_target = 8'hFE;
    #1;
    check("b2b_req", 32'(imem_req), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    check("b2b_addr", 32'(imem_addr), 32'hFE);
    tick();
    check("b2b_r2_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wrap_valid", 32'(instr_valid), 32'd1);
      check("wrap_pc", 32'(instr_pc), 32'(wrap_pcs[k]));
    end

    // Random ready and occasional redirects, scored by the monitor.
    for (int k = 0; k < 400; k++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        branch_taken  = 1'b1;
        branch_target = 8'($urandom);
      end else begin
        branch_taken = 1'b0;
      end
    end
    tick();
    branch_taken = 1'b0;

    // Asynchronous reset with three entries queued.
    instr_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    repeat (4) tick();
    check("pre_reset_count", 32'(fifo_count), 32'd3);
    #1 reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    tick();
    tick();
    reset = 1'b1; instr_ready = 1'b1;
    #1;
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'(RESET_PC));
    tick();
    tick();
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_pc", 32'(instr_pc), 32'(RESET_PC));
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
